pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised elastic register pipeline: a DEPTH-stage chain of WIDTH-bit registers with a per-stage valid bit, valid/ready handshakes on both ends, bubble collapsing, synchronous flush and an occupancy count. It generalises the single asynchronous-reset D flip-flop into a back-pressurable, multi-stage delay line. It is used wherever datapath stages need retiming without losing or duplicating beats under stalls.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data register on reset
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous flush, discards all held beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  pipe can accept a beat this cycle
- in_data  input  WIDTH  upstream beat
- out_valid  output  1  beat present at output stage
- out_ready  input  1  downstream accepts the output beat
- out_data  output  WIDTH  output beat
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- State: stages k=0..DEPTH-1 with v[k] and d[k]. Stage 0 is the input side. Stage DEPTH-1 is the output side.
- Ready chain (combinational): rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready; rdy[k] = ~v[k] | rdy[k+1].
- in_ready = rdy[0] & ~flush.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Stage update on each clock edge, when rdy[k]=1:
  - v[k] <= upstream valid (in_valid & ~flush for k=0, v[k-1] otherwise).
  - d[k] <= upstream data only if the upstream valid is 1; otherwise d[k] holds.
- When rdy[k]=0, stage k holds both v and d.
- Bubble collapsing: an empty stage always accepts, so beats advance into gaps even while the output is stalled.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush or rst.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- flush=1 at an edge:
  - all v[k] <= 0; d[k] hold.
  - in_ready=0 that cycle, so no input is accepted.
  - A beat transferred at the output in the flush cycle counts as delivered; all other beats are discarded.
- count = popcount(v), registered and consistent with v every cycle.
- Width rules: data passes through unmodified. count is wide enough for DEPTH. DEPTH=1 degenerates to a single handshaked register with in_ready = ~v[0] | out_ready.

## Timing
- Reset values (async, immediate): v=0, d=RESET_VAL, out_valid=0, out_data=RESET_VAL, count=0. in_ready=1 unless flush=1.
- rst dominates flush. rst asserted mid-operation drops all beats immediately, without waiting for a clock. The first acceptance is possible at the first edge after rst deasserts.
- Latency, empty pipe: a beat presented with in_valid=1 in cycle 0 is captured at edge 1. out_valid rises in cycle DEPTH (DEPTH edges).
- Throughput: one beat per cycle when out_ready=1 continuously.
- Full pipe (count=DEPTH): in_ready = out_ready combinationally. Simultaneous input and output transfers keep count at DEPTH.
- Empty pipe: out_valid=0, in_ready=1, and out_ready is ignored.
- The only combinational paths are out_ready -> in_ready and flush -> in_ready. out_valid, out_data and count are pure register outputs.

## Test plan
- Reset: hold rst=1 with random inputs. Require out_valid=0, count=0, out_data=RESET_VAL, in_ready=1. Pulse rst mid-stream with count=3 and require count=0 before the next edge.
- Latency and streaming (DEPTH=4): send 0x01..0x08 back-to-back with out_ready=1. Require 0x01 at the output in cycle 4, then one beat per cycle, in order, with count steady at 4.
- Backpressure fill: out_ready=0, send 0xA0..0xA5. Require only 0xA0..0xA3 accepted, in_ready=0 after count=4, and out_data=0xA0 held stable. Release out_ready and require 0xA0..0xA3 out in order.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22, with out_ready=0. Require both stages to compact at the output end (count=2), then output 0x11 then 0x22 with no gap once out_ready=1.
- Full-pipe simultaneous: count=4, in_valid=1 and out_ready=1 for 5 cycles. Require 5 in and 5 out transfers, count=4 throughout, and data order preserved.
- Flush: count=3, assert flush for one cycle with in_valid=1 and out_ready=1. Require in_ready=0, the output beat in that cycle delivered, count=0 after the edge, the in_data of that cycle never emitted, and normal acceptance in the next cycle.

Source files
------------

// File: rtl/pipe_reg_if.sv
// Valid/ready bus for the elastic register pipeline: an input beat stream and an output beat stream.
// Handshake: a beat moves when valid & ready are both high at a rising edge; valid must not wait on ready.
interface pipe_reg_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_reg.sv
// DEPTH-stage elastic register pipeline with per-stage valid, bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    pipe_reg_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH-1:0] v_next;
    logic [CW-1:0]    cnt_next;

    // A stage is ready when empty or when the stage after it will move.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = ~v[DEPTH-1] | bus.out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = bus.in_valid & ~flush;
        up_d[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    // Next valid vector and its popcount, so count always tracks v exactly.
    always_comb begin
        v_next   = '0;
        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                v_next[k] = 1'b0;
            end else if (rdy[k]) begin
                v_next[k] = up_v[k];
            end else begin
                v_next[k] = v[k];
            end
            cnt_next = cnt_next + CW'(v_next[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
        end else begin
            v     <= v_next;
            count <= cnt_next;
            // Data registers only load real beats; bubbles leave them untouched.
            for (int k = 0; k < DEPTH; k++) begin
                if (!flush && rdy[k] && up_v[k]) begin
                    d[k] <= up_d[k];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0] & ~flush;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: scenario tasks plus a queue scoreboard that
// tracks accepted beats and checks every delivered beat, occupancy and in_ready.
module tb_pipe_reg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [2:0] count;

  pipe_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .count(count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int n_in = 0;
  int n_out = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
    bus.in_valid = iv;
    bus.in_data = id;
    bus.out_ready = ordy;
    flush = fl;
  endtask

  // Observe at the falling edge: check occupancy/in_ready, then account for this cycle's transfers.
  task automatic sample();
    logic [WIDTH-1:0] e;
    logic in_x;
    logic out_x;
    logic exp_rdy;
    @(negedge clk);
    in_x = bus.in_valid & bus.in_ready;
    out_x = bus.out_valid & bus.out_ready;
    nchk++;
    if (count !== 3'(exp_q.size())) begin
      nerr++;
      $display("FAIL count: got %0d expected %0d at %0t", count, exp_q.size(), $time);
    end
    exp_rdy = ~flush & ((exp_q.size() < DEPTH) | bus.out_ready);
    nchk++;
    if (bus.in_ready !== exp_rdy) begin
      nerr++;
      $display("FAIL in_ready: got %b expected %b at %0t", bus.in_ready, exp_rdy, $time);
    end
    if (exp_q.size() == 0) begin
      nchk++;
      if (bus.out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL empty_out_valid: got %b expected 0 at %0t", bus.out_valid, $time);
      end
    end
    if (out_x) begin
      n_out++;
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", bus.out_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          nerr++;
          $display("FAIL out_data: got %0h expected %0h at %0t", bus.out_data, e, $time);
        end
      end
    end
    if (flush) exp_q.delete();
    if (in_x) begin
      n_in++;
      exp_q.push_back(bus.in_data);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 30;
    drive(1'b0, '0, 1'b1, 1'b0);
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && budget > 0) begin
      sample();
      advance();
      budget--;
    end
    nchk++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL drain: got %0d beats pending, out_valid %b, expected 0 and 0", exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      nchk += 4;
      if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
      if (count !== 3'd0) begin nerr++; $display("FAIL rst_count: got %0d expected 0", count); end
      if (bus.out_data !== RST_VAL) begin nerr++; $display("FAIL rst_out_data: got %0h expected %0h", bus.out_data, RST_VAL); end
      if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Build count=3, then pulse reset between edges.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'h31 + 8'(c), 1'b0, 1'b0);
      sample();
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    sample();
    nchk++;
    if (count !== 3'd3) begin nerr++; $display("FAIL pre_rst_count: got %0d expected 3", count); end
    #1 rst = 1'b1;
    #1;
    nchk += 3;
    if (count !== 3'd0) begin nerr++; $display("FAIL async_rst_count: got %0d expected 0", count); end
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL async_rst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_data !== RST_VAL) begin nerr++; $display("FAIL async_rst_out_data: got %0h expected %0h", bus.out_data, RST_VAL); end
    exp_q.delete();
    advance();
    rst = 1'b0;
    drive(1'b1, 8'h42, 1'b1, 1'b0);
    sample();
    advance();
    drain();
  endtask

  task automatic test_stream();
    for (int c = 0; c < 14; c++) begin
      drive(c < 8, 8'(c + 1), 1'b1, 1'b0);
      sample();
      nchk++;
      if (bus.out_valid !== ((c >= 4 && c < 12) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL stream_out_valid: cycle %0d got %b", c, bus.out_valid);
      end
      if (c >= 4 && c < 12) begin
        nchk++;
        if (bus.out_data !== 8'(c - 3)) begin nerr++; $display("FAIL stream_data: got %0h expected %0h", bus.out_data, 8'(c - 3)); end
      end
      if (c >= 4 && c <= 8) begin
        nchk++;
        if (count !== 3'd4) begin nerr++; $display("FAIL stream_count: got %0d expected 4", count); end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc0;
    acc0 = n_in;
    for (int c = 0; c < 8; c++) begin
      drive(c < 6, 8'hA0 + 8'(c), 1'b0, 1'b0);
      sample();
      if (c >= 4) begin
        nchk++;
        if (bus.out_data !== 8'hA0 || bus.out_valid !== 1'b1) begin
          nerr++;
          $display("FAIL bp_hold: got %0h/%b expected a0/1", bus.out_data, bus.out_valid);
        end
      end
      advance();
    end
    nchk++;
    if (n_in - acc0 != 4) begin nerr++; $display("FAIL bp_accepted: got %0d expected 4", n_in - acc0); end
    drain();
  endtask

  task automatic test_bubble();
    for (int c = 0; c < 11; c++) begin
      drive(c == 0 || c == 3, (c == 0) ? 8'h11 : 8'h22, c >= 8, 1'b0);
      sample();
      nchk++;
      case (c)
        3: if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bub_early: got %b expected 0", bus.out_valid); end
        6: if (count !== 3'd2) begin nerr++; $display("FAIL bub_count: got %0d expected 2", count); end
        8: if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin nerr++; $display("FAIL bub_first: got %b/%0h expected 1/11", bus.out_valid, bus.out_data); end
        9: if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin nerr++; $display("FAIL bub_second: got %b/%0h expected 1/22", bus.out_valid, bus.out_data); end
        10: if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bub_after: got %b expected 0", bus.out_valid); end
        default: if (bus.out_valid === 1'bx) begin nerr++; $display("FAIL bub_x: got x expected 0/1"); end
      endcase
      advance();
    end
    drain();
  endtask

  task automatic test_full_simul();
    int in0;
    int out0;
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, 8'hB0 + 8'(c), 1'b0, 1'b0);
      sample();
      advance();
    end
    in0 = n_in;
    out0 = n_out;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
      sample();
      nchk++;
      if (count !== 3'd4 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL full_simul: got count %0d in_ready %b out_valid %b expected 4/1/1", count, bus.in_ready, bus.out_valid);
      end
      advance();
    end
    nchk++;
    if (n_in - in0 != 5 || n_out - out0 != 5) begin
      nerr++;
      $display("FAIL full_xfers: got %0d in %0d out expected 5 and 5", n_in - in0, n_out - out0);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      drive(c < 3, 8'hD0 + 8'(c), 1'b0, 1'b0);
      sample();
      advance();
    end
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    sample();
    nchk++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hD0) begin
      nerr++;
      $display("FAIL flush_cycle: got in_ready %b out %b/%0h expected 0 1/d0", bus.in_ready, bus.out_valid, bus.out_data);
    end
    advance();
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    sample();
    nchk++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL post_flush: got count %0d out_valid %b in_ready %b expected 0/0/1", count, bus.out_valid, bus.in_ready);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      sample();
      advance();
    end
    drain();
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_full_simul();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
